// File: rtl/dbg_dump_engine.sv
// End-of-run dump engine: saturating cycle counter plus a sequencer that streams
// the cycle snapshot, every register and a DMEM window as tagged records.
module dbg_dump_engine #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter int REG_AW  = 5,
   parameter int DMEM_AW = 8,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               start,
   input  logic [DMEM_AW-1:0] mem_base,
   input  logic [DMEM_AW:0]   mem_count,
   output logic [REG_AW-1:0]  rf_raddr,
   input  logic [XLEN-1:0]    rf_rdata,
   output logic [DMEM_AW-1:0] dm_raddr,
   input  logic [XLEN-1:0]    dm_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         out_kind,
   output logic [DMEM_AW-1:0] out_index,
   output logic [XLEN-1:0]    out_data,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   cycle_count
);

   typedef enum logic [2:0] {S_IDLE, S_CYC, S_REG, S_MREQ, S_MCAP, S_FIN} state_t;

   localparam logic [1:0]        KIND_CYC = 2'd0;
   localparam logic [1:0]        KIND_REG = 2'd1;
   localparam logic [1:0]        KIND_MEM = 2'd2;
   localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NREGS - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [XLEN-1:0] fit_xlen(input logic [CNT_W-1:0] v);
      return XLEN'(v);
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   snap_q, snap_d;
   logic [DMEM_AW-1:0] base_q, base_d;
   logic [DMEM_AW:0]   count_q, count_d;
   logic [REG_AW-1:0]  idx_q, idx_d;
   logic [DMEM_AW:0]   mi_q, mi_d;
   logic               valid_q, valid_d;
   logic [1:0]         kind_q, kind_d;
   logic [DMEM_AW-1:0] index_q, index_d;
   logic [XLEN-1:0]    data_q, data_d;
   logic               last_q, last_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               slot_free;
   logic [DMEM_AW-1:0] mem_addr;
   logic [DMEM_AW:0]   mi_inc;

   always_comb begin
      slot_free = !valid_q || out_ready;
      mem_addr  = base_q + mi_q[DMEM_AW-1:0];
      mi_inc    = mi_q + (DMEM_AW+1)'(1);

      state_d  = state_q;
      cnt_d    = run ? sat_inc(cnt_q) : cnt_q;
      snap_d   = snap_q;
      base_d   = base_q;
      count_d  = count_q;
      idx_d    = idx_q;
      mi_d     = mi_q;
      valid_d  = (valid_q && out_ready) ? 1'b0 : valid_q;
      kind_d   = kind_q;
      index_d  = index_q;
      data_d   = data_q;
      last_d   = last_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rf_raddr = '0;
      dm_raddr = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = mem_base;
               count_d = mem_count;
               snap_d  = cnt_q;
               idx_d   = '0;
               mi_d    = '0;
               busy_d  = 1'b1;
               state_d = S_CYC;
            end
         end
         S_CYC: begin
            if (slot_free) begin
               valid_d = 1'b1;
               kind_d  = KIND_CYC;
               index_d = '0;
               data_d  = fit_xlen(snap_q);
               last_d  = 1'b0;
               idx_d   = '0;
               state_d = S_REG;
            end
         end
         S_REG: begin
            rf_raddr = idx_q;
            if (slot_free) begin
               valid_d = 1'b1;
               kind_d  = KIND_REG;
               index_d = DMEM_AW'(idx_q);
               data_d  = rf_rdata;
               last_d  = (idx_q == LAST_REG) && (count_q == '0);
               idx_d   = idx_q + REG_AW'(1);
               if (idx_q == LAST_REG)
                  state_d = (count_q != '0) ? S_MREQ : S_FIN;
            end
         end
         // Only advance once the slot is empty after this edge, so MCAP can always load.
         S_MREQ: begin
            dm_raddr = mem_addr;
            if (slot_free) state_d = S_MCAP;
         end
         S_MCAP: begin
            valid_d = 1'b1;
            kind_d  = KIND_MEM;
            index_d = mem_addr;
            data_d  = dm_rdata;
            last_d  = (mi_inc == count_q);
            mi_d    = mi_inc;
            state_d = (mi_inc < count_q) ? S_MREQ : S_FIN;
         end
         S_FIN: begin
            if (valid_q && out_ready) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         snap_q  <= '0;
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         mi_q    <= '0;
         valid_q <= 1'b0;
         kind_q  <= '0;
         index_q <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         base_q  <= base_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         mi_q    <= mi_d;
         valid_q <= valid_d;
         kind_q  <= kind_d;
         index_q <= index_d;
         data_q  <= data_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_kind    = kind_q;
   assign out_index   = index_q;
   assign out_data    = data_q;
   assign out_last    = last_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_dbg_dump_engine.sv
// Randomised bench for dbg_dump_engine: an expected-record queue built from the
// RF/DMEM contents at each accepted start is compared against every handshake.
module tb_dbg_dump_engine;
   localparam int XLEN = 32, NREGS = 32, REG_AW = 5, DMEM_AW = 8, CNT_W = 32;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  idx;
      logic [31:0] data;
      logic        last;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst, run, start, out_ready;
   logic [7:0]  mem_base;
   logic [8:0]  mem_count;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic [7:0]  dm_raddr;
   logic [31:0] dm_rdata;
   logic        out_valid, out_last, busy, done;
   logic [1:0]  out_kind;
   logic [7:0]  out_index;
   logic [31:0] out_data;
   logic [31:0] cycle_count;

   logic        run_s, start_s, ready_s;
   logic [7:0]  base_s;
   logic [8:0]  count_s;
   logic [4:0]  rf_raddr_s;
   logic [31:0] rf_rdata_s, dm_rdata_s;
   logic [7:0]  dm_raddr_s;
   logic        out_valid_s, out_last_s, busy_s, done_s;
   logic [1:0]  out_kind_s;
   logic [7:0]  out_index_s;
   logic [31:0] out_data_s;
   logic [3:0]  cycle_count_s;

   logic [31:0] rf  [NREGS];
   logic [31:0] mem [256];

   dbg_dump_engine #(.XLEN(XLEN), .NREGS(NREGS), .REG_AW(REG_AW), .DMEM_AW(DMEM_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .run(run), .start(start), .mem_base(mem_base), .mem_count(mem_count),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_index(out_index),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .cycle_count(cycle_count));

   dbg_dump_engine #(.XLEN(XLEN), .NREGS(NREGS), .REG_AW(REG_AW), .DMEM_AW(DMEM_AW), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .run(run_s), .start(start_s), .mem_base(base_s), .mem_count(count_s),
      .rf_raddr(rf_raddr_s), .rf_rdata(rf_rdata_s), .dm_raddr(dm_raddr_s), .dm_rdata(dm_rdata_s),
      .out_valid(out_valid_s), .out_ready(ready_s), .out_kind(out_kind_s), .out_index(out_index_s),
      .out_data(out_data_s), .out_last(out_last_s), .busy(busy_s), .done(done_s), .cycle_count(cycle_count_s));

   assign rf_rdata   = rf[rf_raddr];
   assign rf_rdata_s = rf[rf_raddr_s];
   assign dm_rdata_s = 32'd0;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs as seen at each rising edge, for the model.
   logic       live = 1'b0;
   logic       rst_e, run_e, start_e;
   logic [7:0] base_e;
   logic [8:0] count_e;

   always @(posedge clk) begin
      live     <= 1'b1;
      rst_e    <= rst;
      run_e    <= run;
      start_e  <= start;
      base_e   <= mem_base;
      count_e  <= mem_count;
      dm_rdata <= mem[dm_raddr];
   end

   rec_t        exp_q[$];
   rec_t        got_q[$];
   int          got_t[$];
   logic [31:0] cnt_m     = 32'd0;
   logic        busy_m    = 1'b0;
   logic        done_m    = 1'b0;
   logic        last_pend = 1'b0;
   int          cyc       = 0;
   int          last_mem_cyc = -100;
   int          n_done    = 0;
   logic        prev_stall = 1'b0;
   logic        prev_valid = 1'b0;
   rec_t        prev;
   logic [7:0]  dm_h1 = 8'd0, dm_h2 = 8'd0;

   task automatic build(input logic [31:0] snap, input logic [7:0] b, input logic [8:0] c);
      rec_t r;
      r.kind = 2'd0; r.idx = 8'd0; r.data = snap; r.last = 1'b0;
      exp_q.push_back(r);
      for (int i = 0; i < NREGS; i++) begin
         r.kind = 2'd1; r.idx = 8'(i); r.data = rf[i];
         r.last = (i == NREGS - 1) && (c == 9'd0);
         exp_q.push_back(r);
      end
      for (int j = 0; j < int'(c); j++) begin
         r.kind = 2'd2; r.idx = 8'((int'(b) + j) % 256); r.data = mem[r.idx];
         r.last = (j == int'(c) - 1);
         exp_q.push_back(r);
      end
   endtask

   always @(negedge clk) begin : cmp
      rec_t cur, e;
      cyc++;
      if (live) begin
         if (rst_e) begin
            cnt_m = 32'd0; busy_m = 1'b0; done_m = 1'b0; last_pend = 1'b0;
            exp_q.delete();
         end else begin
            if (start_e && !busy_m) begin
               build(cnt_m, base_e, count_e);
               busy_m = 1'b1; done_m = 1'b0; last_mem_cyc = -100;
            end else begin
               done_m = last_pend;
               if (last_pend) busy_m = 1'b0;
            end
            last_pend = 1'b0;
            if (run_e && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
         end
         if (done) n_done++;
         cur.kind = out_kind; cur.idx = out_index; cur.data = out_data; cur.last = out_last;
         if (!rst) begin
            check("cycle_count", 64'(cycle_count), 64'(cnt_m));
            check("busy", 64'(busy), 64'(busy_m));
            check("done", 64'(done), 64'(done_m));
            if (!busy_m) begin
               check("idle_valid", 64'(out_valid), 64'(0));
               check("idle_rf_raddr", 64'(rf_raddr), 64'(0));
               check("idle_dm_raddr", 64'(dm_raddr), 64'(0));
            end
            if (prev_stall) begin
               check("stall_valid", 64'(out_valid), 64'(1));
               check("stall_record", 64'(cur), 64'(prev));
            end
            if (out_valid && out_kind == 2'd2 && !prev_valid) begin
               check("dm_raddr_before_load", 64'(dm_h2), 64'(out_index));
               check("dm_raddr_idle_in_cap", 64'(dm_h1), 64'(0));
            end
            if (out_valid && out_ready) begin
               check("record_pending", 64'(exp_q.size() > 0), 64'(1));
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("record", 64'(cur), 64'(e));
                  got_q.push_back(cur);
                  got_t.push_back(cyc);
                  if (e.kind == 2'd2) begin
                     check("mem_spacing", 64'((cyc - last_mem_cyc) >= 2), 64'(1));
                     last_mem_cyc = cyc;
                  end
                  if (e.last) last_pend = 1'b1;
               end
            end
            prev_stall = out_valid && !out_ready;
         end else begin
            prev_stall = 1'b0;
         end
         prev       = cur;
         prev_valid = out_valid;
         dm_h2      = dm_h1;
         dm_h1      = dm_raddr;
      end
   end

   logic run_fixed = 1'b0, run_rand = 1'b0, rdy_rand = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      run       = run_rand ? 1'($urandom_range(0, 1)) : run_fixed;
   endtask

   task automatic wait_done(input int bound, input string name);
      int d0 = n_done;
      int k  = 0;
      while (n_done == d0 && k < bound) begin
         tick();
         k++;
      end
      check({name, "_completed"}, 64'(n_done != d0), 64'(1));
      tick();
      check({name, "_queue_drained"}, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_dump(input logic [7:0] b, input logic [8:0] c);
      mem_base  = b;
      mem_count = c;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, k;
      logic [8:0] c;
      rst = 1'b1; run = 1'b0; start = 1'b0; out_ready = 1'b1; mem_base = '0; mem_count = '0;
      run_s = 1'b0; start_s = 1'b0; ready_s = 1'b1; base_s = '0; count_s = '0;
      for (int i = 0; i < NREGS; i++) rf[i] = 32'(i * 3);
      for (int j = 0; j < 256; j++) mem[j] = $urandom;
      mem[12]  = 32'hDEAD_BEEF;
      mem[255] = 32'hA5A5_0001;
      mem[0]   = 32'h5A5A_0002;
      repeat (3) tick();
      check("reset_valid", 64'(out_valid), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_count", 64'(cycle_count), 64'(0));
      check("reset_last", 64'(out_last), 64'(0));

      // Cycle count then a register-only dump at full rate
      rst = 1'b0; run_fixed = 1'b1; run = 1'b1;
      repeat (62) tick();
      run_fixed = 1'b0; run = 1'b0;
      check("count_after_62", 64'(cycle_count), 64'(62));
      n0 = got_q.size();
      do_dump(8'd0, 9'd0);
      wait_done(200, "regdump");
      check("regdump_records", 64'(got_q.size() - n0), 64'(33));
      if (got_q.size() >= n0 + 33) begin
         check("regdump_rec0_kind", 64'(got_q[n0].kind), 64'(0));
         check("regdump_rec0_data", 64'(got_q[n0].data), 64'(62));
         check("regdump_reg5_data", 64'(got_q[n0+6].data), 64'(15));
         check("regdump_reg31_idx", 64'(got_q[n0+32].idx), 64'(31));
         check("regdump_reg31_data", 64'(got_q[n0+32].data), 64'(93));
         check("regdump_reg31_last", 64'(got_q[n0+32].last), 64'(1));
         check("regdump_span", 64'(got_t[n0+32] - got_t[n0]), 64'(32));
      end

      // Single memory word
      n0 = got_q.size();
      do_dump(8'd12, 9'd1);
      wait_done(200, "onemem");
      check("onemem_records", 64'(got_q.size() - n0), 64'(34));
      if (got_q.size() >= n0 + 34) begin
         check("onemem_reg31_last", 64'(got_q[n0+32].last), 64'(0));
         check("onemem_kind", 64'(got_q[n0+33].kind), 64'(2));
         check("onemem_idx", 64'(got_q[n0+33].idx), 64'(12));
         check("onemem_data", 64'(got_q[n0+33].data), 64'(32'hDEAD_BEEF));
         check("onemem_last", 64'(got_q[n0+33].last), 64'(1));
      end

      // Backpressure with run toggling, plus a start while busy
      rdy_rand = 1'b1; run_rand = 1'b1;
      n0 = got_q.size();
      do_dump(8'($urandom), 9'd4);
      repeat (15) tick();
      mem_base = 8'd3; mem_count = 9'd7; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(1000, "backpressure");
      check("backpressure_records", 64'(got_q.size() - n0), 64'(37));

      // Address wrap
      n0 = got_q.size();
      do_dump(8'd255, 9'd2);
      wait_done(1000, "wrap");
      check("wrap_records", 64'(got_q.size() - n0), 64'(35));
      if (got_q.size() >= n0 + 35) begin
         check("wrap_idx0", 64'(got_q[n0+33].idx), 64'(255));
         check("wrap_data0", 64'(got_q[n0+33].data), 64'(32'hA5A5_0001));
         check("wrap_idx1", 64'(got_q[n0+34].idx), 64'(0));
         check("wrap_data1", 64'(got_q[n0+34].data), 64'(32'h5A5A_0002));
         check("wrap_last", 64'(got_q[n0+34].last), 64'(1));
      end

      // Reset in the middle of the register phase
      rdy_rand = 1'b0;
      do_dump(8'($urandom), 9'd3);
      k = 0;
      while (!(out_valid && out_kind == 2'd1 && out_index == 8'd10) && k < 100) begin
         tick();
         k++;
      end
      check("reg10_reached", 64'(k < 100), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_valid", 64'(out_valid), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_count", 64'(cycle_count), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      repeat (5) tick();

      // Full dump after the abort, random window, random backpressure
      rdy_rand = 1'b1;
      for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
      c = 9'($urandom_range(0, 5));
      n0 = got_q.size();
      do_dump(8'($urandom), c);
      wait_done(1000, "after_abort");
      check("after_abort_records", 64'(got_q.size() - n0), 64'(33 + int'(c)));
      rdy_rand = 1'b0; run_rand = 1'b0;

      // Saturating 4-bit counter
      run_s = 1'b1;
      repeat (20) tick();
      check("sat_count", 64'(cycle_count_s), 64'(15));
      repeat (3) tick();
      check("sat_hold", 64'(cycle_count_s), 64'(15));
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      k = 0;
      while (!out_valid_s && k < 10) begin
         tick();
         k++;
      end
      check("sat_record_seen", 64'(out_valid_s), 64'(1));
      check("sat_record_kind", 64'(out_kind_s), 64'(0));
      check("sat_record_data", 64'(out_data_s), 64'(15));
      check("sat_record_index", 64'(out_index_s), 64'(0));
      check("sat_record_last", 64'(out_last_s), 64'(0));
      check("sat_busy", 64'(busy_s), 64'(1));
      check("sat_done", 64'(done_s), 64'(0));
      check("sat_dm_raddr", 64'(dm_raddr_s), 64'(0));
      repeat (40) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dbg_dump_engine.md
Name: dbg_dump_engine

Overview:
- Synthesizable end-of-run dump engine for the RISC-V core; successor to the bench-only register/memory printout.
- Counts execution cycles while the core runs.
- On `start`, walks the register file and then a programmable data-memory window.
- Emits each item as a tagged record on a valid/ready stream, for a UART/trace sink or a bench scoreboard.
- Sits beside data_path, sharing the RF debug read port and a DMEM debug read port.

Parameters:
- XLEN, 32, data width of RF/DMEM words and record data
- NREGS, 32, number of registers dumped (indices 0..NREGS-1)
- REG_AW, 5, RF read-address width (2^REG_AW >= NREGS)
- DMEM_AW, 8, DMEM word-address width; also width of out_index
- CNT_W, 32, cycle-counter width (saturating)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- run  in  1  core running; cycle counter increments while high
- start  in  1  dump request, sampled in IDLE only
- mem_base  in  DMEM_AW  first DMEM word address of window, sampled at start
- mem_count  in  DMEM_AW+1  number of DMEM words, sampled at start; 0 = none
- rf_raddr  out  REG_AW  RF debug read address
- rf_rdata  in  XLEN  RF debug read data, combinational, same cycle
- dm_raddr  out  DMEM_AW  DMEM debug read address
- dm_rdata  in  XLEN  DMEM debug read data, valid 1 cycle after address
- out_valid  out  1  record valid
- out_ready  in  1  sink accepts record
- out_kind  out  2  0 = cycle count, 1 = register, 2 = memory
- out_index  out  DMEM_AW  register or DMEM address (0 for kind 0)
- out_data  out  XLEN  record payload
- out_last  out  1  final record of dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse at dump completion
- cycle_count  out  CNT_W  live cycle counter

Behaviour:
- Synchronous reset, active-high. All outputs and state are 0 out of reset; FSM goes to IDLE. Reset mid-dump aborts immediately: out_valid=0 the next cycle, no done pulse.
- Cycle counter: +1 per clk while run=1. Holds while run=0. Saturates at 2^CNT_W-1.
- Output register is a single record slot.
  - The slot may load on any edge where out_valid=0 or out_ready=1.
  - While out_valid=1 and out_ready=0, out_kind/out_index/out_data/out_last hold stable.
- FSM states: IDLE, CYC, REG, MREQ, MCAP, FIN.
- IDLE:
  - start=1 → latch mem_base, mem_count and a snapshot of cycle_count; busy=1; go to CYC.
  - start while busy is ignored.
- CYC: when the slot is free, load kind0 record. Data = snapshot, zero-extended or truncated to XLEN. Go to REG with idx=0.
- REG:
  - rf_raddr=idx.
  - When the slot is free, load kind1 record (index=idx, data=rf_rdata) and increment idx.
  - Sustains 1 record/cycle when out_ready is held high.
  - After idx=NREGS-1 loads, go to MREQ if mem_count>0, else FIN.
- MREQ: drive dm_raddr=(base+i) mod 2^DMEM_AW. Issue only when the slot will be free at the next edge; go to MCAP.
- MCAP:
  - Load kind2 record (index=base+i wrapped, data=dm_rdata). Increment i.
  - Return to MREQ while i<count, else go to FIN.
  - Memory records emit at most 1 per 2 cycles.
- out_last=1 on the final record only: the last memory record, or register NREGS-1 when mem_count=0.
- FIN: after the last record handshakes (out_valid & out_ready), done=1 for exactly one cycle, busy=0, return to IDLE. No records are lost or duplicated.
- run may stay high during the dump: the counter keeps counting, but the snapshot in record 0 stays fixed.
- rf_raddr and dm_raddr are 0 when not in use.

Test Plan:
- Cycle count and register dump:
  - Stimulus: run=1 for 62 cycles, then run=0; start with mem_count=0, out_ready=1, RF preloaded reg[i]=i*3.
  - Required: 33 records on 33 consecutive cycles — kind0 data=62, then kind1 idx 0..31 data i*3; out_last on idx31; done pulses 1 cycle after that.
- Single memory word:
  - Stimulus: mem_base=12, mem_count=1, ram[12]=0xDEADBEEF.
  - Required: a kind2 record index=12 data=0xDEADBEEF with out_last=1 follows reg31; dm_raddr=12 exactly one cycle before the record loads.
- Backpressure:
  - Stimulus: mem_count=4, out_ready pseudo-random.
  - Required: record fields stable while stalled; the sink sees exactly 1+32+4 records, in order, with no duplicates.
- Address wrap:
  - Stimulus: DMEM_AW=8, mem_base=255, mem_count=2.
  - Required: memory indices 255 then 0, with matching data.
- Reset and ignored start:
  - Stimulus: rst asserted during the REG phase at idx 10.
  - Required: next cycle out_valid=0, busy=0, cycle_count=0, no done pulse; a new start gives a full dump.
  - Also: start pulsed while busy has no effect.
- Counter saturation:
  - Stimulus: CNT_W=4, run=1 for 20 cycles.
  - Required: cycle_count=15 and held; record 0 data=15.
